// File: rtl/mesi_isc_broad_cntl_n.sv
// Broadcast controller for the MESI ISC interconnect. It serves one FIFO entry at a time: snoop, enable the initiator, then pop.
// Optional ack timeout is built when MESI_ISC_BROAD_TIMEOUT_EN is defined.
module mesi_isc_broad_cntl_n #(
    parameter int CPU_COUNT        = 4,
    parameter int CPU_ID_WIDTH     = 2,
    parameter int CBUS_CMD_WIDTH   = 3,
    parameter int BROAD_TYPE_WIDTH = 2,
    parameter int BROAD_ID_WIDTH   = 5,
    parameter int TIMEOUT_CYCLES   = 255
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [CPU_COUNT-1:0]                cbus_ack_array_i,
    input  logic [CPU_COUNT-1:0]                snoop_mask_i,
    input  logic                                fifo_status_empty_i,
    input  logic                                fifo_status_full_i,
    input  logic [BROAD_TYPE_WIDTH-1:0]         broad_snoop_type_i,
    input  logic [CPU_ID_WIDTH-1:0]             broad_snoop_cpu_id_i,
    input  logic [BROAD_ID_WIDTH-1:0]           broad_snoop_id_i,
    output logic [CPU_COUNT*CBUS_CMD_WIDTH-1:0] cbus_cmd_array_o,
    output logic                                broad_fifo_rd_o,
    output logic                                busy_o,
    output logic [BROAD_ID_WIDTH-1:0]           active_id_o,
    output logic                                timeout_o,
    output logic [CPU_COUNT-1:0]                timeout_cpu_array_o
);

    localparam logic [CBUS_CMD_WIDTH-1:0]   CMD_NOP      = CBUS_CMD_WIDTH'(0);
    localparam logic [CBUS_CMD_WIDTH-1:0]   CMD_WR_SNOOP = CBUS_CMD_WIDTH'(1);
    localparam logic [CBUS_CMD_WIDTH-1:0]   CMD_RD_SNOOP = CBUS_CMD_WIDTH'(2);
    localparam logic [CBUS_CMD_WIDTH-1:0]   CMD_EN_WR    = CBUS_CMD_WIDTH'(3);
    localparam logic [CBUS_CMD_WIDTH-1:0]   CMD_EN_RD    = CBUS_CMD_WIDTH'(4);
    localparam logic [BROAD_TYPE_WIDTH-1:0] BREQ_TYPE_WR = BROAD_TYPE_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, SNOOP, ENABLE, POP} state_t;

    state_t                      state;
    logic [BROAD_TYPE_WIDTH-1:0] type_q;
    logic [CPU_ID_WIDTH-1:0]     cpu_q;
    logic [CPU_COUNT-1:0]        pending;
    logic [CPU_COUNT-1:0]        pending_next;
    logic [CPU_COUNT-1:0]        head_onehot;
    logic [CPU_COUNT-1:0]        head_pending;
    logic [CPU_COUNT-1:0]        init_onehot;
    logic                        head_invalid;
    logic                        is_wr;

    always_comb begin
        head_onehot = '0;
        init_onehot = '0;
        for (int i = 0; i < CPU_COUNT; i++) begin
            head_onehot[i] = (broad_snoop_cpu_id_i == CPU_ID_WIDTH'(i));
            init_onehot[i] = (cpu_q == CPU_ID_WIDTH'(i));
        end
    end

    assign head_invalid = ({1'b0, broad_snoop_cpu_id_i} >= (CPU_ID_WIDTH+1)'(CPU_COUNT));
    assign head_pending = snoop_mask_i & ~head_onehot;
    assign pending_next = pending & ~cbus_ack_array_i;
    assign is_wr        = (type_q == BREQ_TYPE_WR);

    assign broad_fifo_rd_o = (state == POP);
    assign busy_o          = (state != IDLE);

    // Commands come only from latched request state, never from the live FIFO head.
    always_comb begin
        cbus_cmd_array_o = {CPU_COUNT{CMD_NOP}};
        for (int i = 0; i < CPU_COUNT; i++) begin
            if (state == SNOOP && pending[i]) begin
                cbus_cmd_array_o[i*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] = is_wr ? CMD_WR_SNOOP : CMD_RD_SNOOP;
            end else if (state == ENABLE && init_onehot[i]) begin
                cbus_cmd_array_o[i*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] = is_wr ? CMD_EN_WR : CMD_EN_RD;
            end
        end
    end

`ifdef MESI_ISC_BROAD_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] tmo_cnt;
    logic        tmo_hit;
    logic        unused_inputs;

    assign tmo_hit       = (tmo_cnt == TMO_LAST);
    assign unused_inputs = fifo_status_full_i;
`else
    logic unused_inputs;

    assign timeout_o           = 1'b0;
    assign timeout_cpu_array_o = '0;
    assign unused_inputs       = fifo_status_full_i | (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            type_q      <= '0;
            cpu_q       <= '0;
            pending     <= '0;
            active_id_o <= '0;
`ifdef MESI_ISC_BROAD_TIMEOUT_EN
            tmo_cnt             <= '0;
            timeout_o           <= 1'b0;
            timeout_cpu_array_o <= '0;
`endif
        end else begin
`ifdef MESI_ISC_BROAD_TIMEOUT_EN
            timeout_o <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!fifo_status_empty_i) begin
                        type_q      <= broad_snoop_type_i;
                        cpu_q       <= broad_snoop_cpu_id_i;
                        active_id_o <= broad_snoop_id_i;
                        pending     <= head_pending;
`ifdef MESI_ISC_BROAD_TIMEOUT_EN
                        tmo_cnt             <= '0;
                        timeout_cpu_array_o <= '0;
`endif
                        if (head_invalid) begin
                            state <= POP;
                        end else if (|head_pending) begin
                            state <= SNOOP;
                        end else begin
                            state <= ENABLE;
                        end
                    end
                end
                SNOOP: begin
                    pending <= pending_next;
                    if (pending_next == '0) begin
                        state <= ENABLE;
`ifdef MESI_ISC_BROAD_TIMEOUT_EN
                        tmo_cnt <= '0;
                    end else if (tmo_hit) begin
                        // A CPU acking on the expiry cycle is not reported as timed out.
                        timeout_o           <= 1'b1;
                        timeout_cpu_array_o <= pending_next;
                        pending             <= '0;
                        tmo_cnt             <= '0;
                        state               <= ENABLE;
                    end else begin
                        tmo_cnt <= (pending_next != pending) ? 16'd0 : tmo_cnt + 16'd1;
`endif
                    end
                end
                ENABLE: begin
                    if (|(cbus_ack_array_i & init_onehot)) begin
                        state <= POP;
                    end
`ifdef MESI_ISC_BROAD_TIMEOUT_EN
                    else if (tmo_hit) begin
                        timeout_o           <= 1'b1;
                        timeout_cpu_array_o <= init_onehot;
                        state               <= POP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
`endif
                end
                POP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mesi_isc_broad_cntl_n.sv
// Self-checking bench for mesi_isc_broad_cntl_n: a per-request timeline model drives a per-cycle compare process.
module tb_mesi_isc_broad_cntl_n;

    localparam logic [1:0] WR = 2'd1;
    localparam logic [1:0] RD = 2'd2;

    logic        clk;
    logic        rst;
    logic [3:0]  ackIn;
    logic [3:0]  maskIn;
    logic        emptyIn;
    logic        fullIn;
    logic [1:0]  typeIn;
    logic [1:0]  cpuIn;
    logic [4:0]  idIn;
    logic [11:0] cmdOut;
    logic        rdOut;
    logic        busyOut;
    logic [4:0]  activeIdOut;
    logic        tmoOut;
    logic [3:0]  tmoArrOut;

    logic [2:0]  ack3;
    logic [2:0]  mask3;
    logic        empty3;
    logic [1:0]  type3;
    logic [1:0]  cpu3;
    logic [4:0]  id3;
    logic [8:0]  cmd3;
    logic        rd3;
    logic        busy3;
    logic [4:0]  activeId3;
    logic        tmo3;
    logic [2:0]  tmoArr3;

    logic [11:0] expCmd;
    logic        expRd;
    logic        expBusy;
    logic [4:0]  expActiveId;
    logic        expTmo;
    logic [3:0]  expTmoArr;
    bit          checkEn;
    int          checks;
    int          errors;

    mesi_isc_broad_cntl_n #(
        .CPU_COUNT(4), .CPU_ID_WIDTH(2), .CBUS_CMD_WIDTH(3),
        .BROAD_TYPE_WIDTH(2), .BROAD_ID_WIDTH(5), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .cbus_ack_array_i(ackIn), .snoop_mask_i(maskIn),
        .fifo_status_empty_i(emptyIn), .fifo_status_full_i(fullIn),
        .broad_snoop_type_i(typeIn), .broad_snoop_cpu_id_i(cpuIn), .broad_snoop_id_i(idIn),
        .cbus_cmd_array_o(cmdOut), .broad_fifo_rd_o(rdOut), .busy_o(busyOut),
        .active_id_o(activeIdOut), .timeout_o(tmoOut), .timeout_cpu_array_o(tmoArrOut)
    );

    mesi_isc_broad_cntl_n #(
        .CPU_COUNT(3), .CPU_ID_WIDTH(2), .CBUS_CMD_WIDTH(3),
        .BROAD_TYPE_WIDTH(2), .BROAD_ID_WIDTH(5), .TIMEOUT_CYCLES(8)
    ) dut3 (
        .clk(clk), .rst(rst),
        .cbus_ack_array_i(ack3), .snoop_mask_i(mask3),
        .fifo_status_empty_i(empty3), .fifo_status_full_i(fullIn),
        .broad_snoop_type_i(type3), .broad_snoop_cpu_id_i(cpu3), .broad_snoop_id_i(id3),
        .cbus_cmd_array_o(cmd3), .broad_fifo_rd_o(rd3), .busy_o(busy3),
        .active_id_o(activeId3), .timeout_o(tmo3), .timeout_cpu_array_o(tmoArr3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("cmd_cpu%0d", i), 32'(cmdOut[i*3 +: 3]), 32'(expCmd[i*3 +: 3]));
        end
        check("fifo_rd", 32'(rdOut), 32'(expRd));
        check("busy", 32'(busyOut), 32'(expBusy));
        check("active_id", 32'(activeIdOut), 32'(expActiveId));
        check("timeout", 32'(tmoOut), 32'(expTmo));
        check("timeout_cpus", 32'(tmoArrOut), 32'(expTmoArr));
    endtask

    always @(negedge clk) begin
        if (checkEn) checkOutput();
    end

    // One request: dly holds per-CPU snoop ack offsets (4 bits each), initDly the initiator's enable ack offset.
    // A silent CPU never acks; its dly entry is then the snoop cycle on which the timeout expires.
    task automatic applyStimulus(input logic [1:0] typ, input logic [1:0] cpu, input logic [4:0] id,
                                 input logic [3:0] mask, input logic [15:0] dly, input int initDly,
                                 input logic [3:0] silent, input bit tmoSnoop);
        logic [3:0]  pend;
        logic [3:0]  initBit;
        int          snoopLen;
        int          d;
        logic [11:0] cmd;
        initBit  = 4'b0001 << cpu;
        pend     = mask & ~initBit;
        snoopLen = 0;
        for (int i = 0; i < 4; i++) begin
            d = int'(dly[i*4 +: 4]);
            if (pend[i] && d + 1 > snoopLen) snoopLen = d + 1;
        end
        typeIn = typ; cpuIn = cpu; idIn = id; maskIn = mask; emptyIn = 1'b0;
        @(posedge clk); #1;
        emptyIn = 1'b1; typeIn = ~typ; cpuIn = cpu + 2'd1; idIn = ~id; maskIn = ~mask;
        expBusy = 1'b1; expActiveId = id; expTmoArr = 4'b0000; expRd = 1'b0; expTmo = 1'b0;
        for (int s = 0; s < snoopLen; s++) begin
            cmd   = '0;
            ackIn = ~mask | ((s == 0) ? initBit : 4'b0000);
            for (int i = 0; i < 4; i++) begin
                d = int'(dly[i*4 +: 4]);
                if (pend[i] && s <= d) cmd[i*3 +: 3] = (typ == WR) ? 3'd1 : 3'd2;
                if (pend[i] && s == d && !silent[i]) ackIn[i] = 1'b1;
            end
            expCmd = cmd;
            @(posedge clk); #1;
        end
        for (int e = 0; e <= initDly; e++) begin
            cmd = '0;
            cmd[int'(cpu)*3 +: 3] = (typ == WR) ? 3'd3 : 3'd4;
            expCmd = cmd;
            ackIn  = ~initBit | ((e == initDly) ? initBit : 4'b0000);
            expTmo = tmoSnoop && (e == 0);
            if (tmoSnoop) expTmoArr = silent & pend;
            @(posedge clk); #1;
        end
        expCmd = '0; expRd = 1'b1; expTmo = 1'b0; ackIn = 4'hF;
        @(posedge clk); #1;
        expRd = 1'b0; expBusy = 1'b0;
        @(posedge clk); #1;
        ackIn = 4'h0;
    endtask

    initial begin
        checks = 0; errors = 0; checkEn = 0;
        rst = 1'b0; ackIn = '0; maskIn = '0; emptyIn = 1'b1; fullIn = 1'b0;
        typeIn = '0; cpuIn = '0; idIn = '0;
        ack3 = '0; mask3 = '0; empty3 = 1'b1; type3 = '0; cpu3 = '0; id3 = '0;
        expCmd = '0; expRd = 1'b0; expBusy = 1'b0; expActiveId = '0; expTmo = 1'b0; expTmoArr = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_cmds", 32'(cmdOut), 32'h0);
        check("reset_rd", 32'(rdOut), 32'h0);
        check("reset_busy", 32'(busyOut), 32'h0);
        check("reset_id", 32'(activeIdOut), 32'h0);
        check("reset_tmo", 32'(tmoOut), 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        checkEn = 1;

        $display("[TB] WR from cpu2, all acks immediate");
        fork
            applyStimulus(WR, 2'd2, 5'd5, 4'hF, 16'h0000, 0, 4'h0, 1'b0);
            begin
                @(posedge clk);
                @(negedge clk);
                check("t1_snoop_cmds", 32'(cmdOut), 32'(12'o1011));
                @(negedge clk);
                check("t1_enable_cmds", 32'(cmdOut), 32'(12'o0300));
                @(negedge clk);
                check("t1_pop", 32'(rdOut), 32'h1);
                check("t1_active_id", 32'(activeIdOut), 32'd5);
            end
        join

        $display("[TB] RD from cpu0, cpu3 acks three cycles late");
        applyStimulus(RD, 2'd0, 5'd12, 4'hF, 16'h3000, 0, 4'h0, 1'b0);

        $display("[TB] mask selects only the initiator");
        fork
            applyStimulus(RD, 2'd0, 5'd3, 4'b0001, 16'h0000, 0, 4'h0, 1'b0);
            begin
                @(posedge clk);
                @(negedge clk);
                check("t3_enable_cmds", 32'(cmdOut), 32'(12'o0004));
                @(negedge clk);
                check("t3_pop", 32'(rdOut), 32'h1);
            end
        join

        $display("[TB] WR from cpu3, partial mask, slow initiator");
        applyStimulus(WR, 2'd3, 5'd17, 4'b0110, 16'h0020, 2, 4'h0, 1'b0);

        $display("[TB] out-of-range initiator on 3-CPU instance");
        empty3 = 1'b0; cpu3 = 2'd3; mask3 = 3'b111; type3 = WR; id3 = 5'd7; ack3 = 3'b111;
        @(posedge clk); #1;
        empty3 = 1'b1;
        @(negedge clk);
        check("c3_cmds", 32'(cmd3), 32'h0);
        check("c3_pop", 32'(rd3), 32'h1);
        check("c3_busy", 32'(busy3), 32'h1);
        check("c3_id", 32'(activeId3), 32'd7);
        @(posedge clk); #1;
        @(negedge clk);
        check("c3_idle_busy", 32'(busy3), 32'h0);
        check("c3_idle_rd", 32'(rd3), 32'h0);
        ack3 = '0;

        $display("[TB] reset asserted during ENABLE");
        @(posedge clk); #1;
        checkEn = 0;
        typeIn = WR; cpuIn = 2'd1; idIn = 5'd9; maskIn = 4'b0000; emptyIn = 1'b0;
        @(posedge clk); #1;
        emptyIn = 1'b1;
        check("rst_pre_enable", 32'(cmdOut), 32'(12'o0030));
        #2 rst = 1'b0;
        #1;
        check("rst_cmds", 32'(cmdOut), 32'h0);
        check("rst_rd", 32'(rdOut), 32'h0);
        check("rst_busy", 32'(busyOut), 32'h0);
        check("rst_id", 32'(activeIdOut), 32'h0);
        @(posedge clk); #1;
        check("rst_held_rd", 32'(rdOut), 32'h0);
        rst = 1'b1;
        expCmd = '0; expRd = 1'b0; expBusy = 1'b0; expActiveId = '0; expTmo = 1'b0; expTmoArr = '0;
        @(posedge clk); #1;
        checkEn = 1;
        applyStimulus(RD, 2'd1, 5'd21, 4'hF, 16'h0100, 1, 4'h0, 1'b0);

`ifdef MESI_ISC_BROAD_TIMEOUT_EN
        $display("[TB] cpu1 never acks, timeout after 8 idle cycles");
        fork
            applyStimulus(WR, 2'd0, 5'd9, 4'hF, 16'h0080, 0, 4'b0010, 1'b1);
            begin
                @(posedge clk);
                repeat (10) @(negedge clk);
                check("tmo_pulse", 32'(tmoOut), 32'h1);
                check("tmo_cpus", 32'(tmoArrOut), 32'h2);
            end
        join
`endif

        checkEn = 0;
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
